// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - IF stage control, instruction memory and IF/ID bundle
// master: the fetch stage; slave: the surrounding pipeline and instruction memory.
interface instruction_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] NPC_IF;
  logic [15:0] INST_IF;
  logic        BRANCH_PRED;
  logic        VALID_IF;

  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  resolve_valid, resolve_pc, resolve_taken,
    input  imem_data,
    output imem_addr, NPC_IF, INST_IF, BRANCH_PRED, VALID_IF
  );

  modport slave (
    output stall, redirect_valid, redirect_pc,
    output resolve_valid, resolve_pc, resolve_taken,
    output imem_data,
    input  imem_addr, NPC_IF, INST_IF, BRANCH_PRED, VALID_IF
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, branch prediction, IF/ID register
// BPRED_TABLE_EN selects a 2-bit counter table predictor instead of static BTFN.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [3:0]  BRANCH_OPCODE  = 4'hC,
  parameter logic [15:0] NOP_INST       = 16'h0000,
  parameter int          BHT_INDEX_BITS = 4
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  logic [15:0] r_pc;
  logic [15:0] r_npc;
  logic [15:0] r_inst;
  logic        r_pred;
  logic        r_valid;

  logic [15:0] w_pc_plus1;
  logic [15:0] w_imm;
  logic [15:0] w_target;
  logic        w_is_br;
  logic        w_pred_taken;
  logic        w_pred;

  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_is_br    = (bus.imem_data[15:12] == BRANCH_OPCODE);
  assign w_imm      = {{9{bus.imem_data[11]}}, bus.imem_data[11:5]};
  assign w_target   = w_pc_plus1 + w_imm;
  assign w_pred     = w_is_br & w_pred_taken;

`ifdef BPRED_TABLE_EN
  localparam int BHT_SIZE = 1 << BHT_INDEX_BITS;

  logic [1:0]                r_bht [BHT_SIZE];
  logic [BHT_INDEX_BITS-1:0] w_lookup_idx;
  logic [BHT_INDEX_BITS-1:0] w_update_idx;

  assign w_lookup_idx = r_pc[BHT_INDEX_BITS-1:0];
  assign w_update_idx = bus.resolve_pc[BHT_INDEX_BITS-1:0];
  // Registered table: a same-cycle lookup naturally sees the pre-update count.
  assign w_pred_taken = r_bht[w_lookup_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_SIZE; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (bus.resolve_valid) begin
      if (bus.resolve_taken) begin
        if (r_bht[w_update_idx] != 2'b11) r_bht[w_update_idx] <= r_bht[w_update_idx] + 2'd1;
      end else begin
        if (r_bht[w_update_idx] != 2'b00) r_bht[w_update_idx] <= r_bht[w_update_idx] - 2'd1;
      end
    end
  end
`else
  localparam int lp_unused_bht_bits = BHT_INDEX_BITS;

  logic w_unused_resolve;

  // Backward-taken / forward-not-taken: the offset sign bit is the prediction.
  assign w_pred_taken     = bus.imem_data[11];
  assign w_unused_resolve = ^{bus.resolve_valid, bus.resolve_pc, bus.resolve_taken};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_npc   <= 16'h0000;
      r_inst  <= NOP_INST;
      r_pred  <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc    <= bus.redirect_pc;
      r_npc   <= 16'h0000;
      r_inst  <= NOP_INST;
      r_pred  <= 1'b0;
      r_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc    <= w_pred ? w_target : w_pc_plus1;
      r_npc   <= w_pc_plus1;
      r_inst  <= bus.imem_data;
      r_pred  <= w_pred;
      r_valid <= 1'b1;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.NPC_IF      = r_npc;
  assign bus.INST_IF     = r_inst;
  assign bus.BRANCH_PRED = r_pred;
  assign bus.VALID_IF    = r_valid;

endmodule
